// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receiver / host and the receive FIFO.
// Handshake: Push_Data is a one-cycle strobe with no back-pressure. A push
// that cannot be stored is dropped and flagged on FIFO_Overflow. Pop_Data is
// level-sampled; each cycle it is high with Count > 0 pops one entry, and
// that entry is visible on Data_Out/Err_Out the following cycle.
interface uart_rx_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_WIDTH = 8
);
   logic                  Push_Data;
   logic [DATA_BITS-1:0]  Data_In;
   logic [2:0]            Err_In;
   logic                  Pop_Data;
   logic [DATA_BITS-1:0]  Data_Out;
   logic [2:0]            Err_Out;
   logic                  FIFO_Empty;
   logic                  FIFO_Full;
   logic                  FIFO_Overflow;
   logic                  RTS;
   logic [FIFO_WIDTH:0]   Count;
   logic                  Rts_Hold_Dbg;   // RTS state machine: 1 = HOLD, 0 = SEND

   modport slave (
      input  Push_Data, Data_In, Err_In, Pop_Data,
      output Data_Out, Err_Out, FIFO_Empty, FIFO_Full, FIFO_Overflow, RTS,
             Count, Rts_Hold_Dbg
   );

   modport master (
      output Push_Data, Data_In, Err_In, Pop_Data,
      input  Data_Out, Err_Out, FIFO_Empty, FIFO_Full, FIFO_Overflow, RTS,
             Count, Rts_Hold_Dbg
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: circular buffer of {err, data} frames with registered
// pop output, Empty/Full/Overflow flags and RTS flow control with hysteresis.
// Optional feature macro: UART_RX_FIFO_ERR_DROP_EN -- when defined, frames
// with a non-zero error code are discarded at the push side.
module uart_rx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_WIDTH = 8
) (
   input  logic           Clk,
   input  logic           Rst,
   uart_rx_fifo_if.slave  bus
);
   localparam int ENTRIES = 2 ** FIFO_WIDTH;
   localparam int CNT_W   = FIFO_WIDTH + 1;
   localparam int WORD_W  = DATA_BITS + 3;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ENTRIES);
   localparam logic [CNT_W-1:0] FULL_TH  = CNT_W'(ENTRIES / 2 + 1);
   localparam logic [CNT_W-1:0] LOW_TH   = CNT_W'(ENTRIES / 4);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {
      RTS_SEND = 1'b0,
      RTS_HOLD = 1'b1
   } rts_state_e;

   logic [WORD_W-1:0]     mem [ENTRIES];

   logic [FIFO_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DATA_BITS-1:0]  data_out_q, data_out_d;
   logic [2:0]            err_out_q, err_out_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   logic                  ovf_q, ovf_d;
   rts_state_e            state_q, state_d;

   logic                  err_ok;
   logic                  pop_acc;
   logic                  push_acc;
   logic                  push_drop;
   logic [WORD_W-1:0]     rd_word;

   // Accept/drop decisions for this cycle's push and pop.
   always_comb begin
`ifdef UART_RX_FIFO_ERR_DROP_EN
      err_ok = (bus.Err_In == 3'b000);
`else
      err_ok = 1'b1;
`endif
      pop_acc   = bus.Pop_Data && (count_q != CNT_ZERO);
      // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
      push_acc  = bus.Push_Data && err_ok && ((count_q < CNT_MAX) || pop_acc);
      push_drop = bus.Push_Data && err_ok && (count_q == CNT_MAX) && !pop_acc;
      rd_word   = mem[rd_ptr_q];
   end

   // Next pointers, count, output register and flags derived from next count.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      data_out_d = data_out_q;
      err_out_d  = err_out_q;
      ovf_d      = ovf_q;

      if (push_acc) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_acc) begin
         rd_ptr_d   = rd_ptr_q + 1'b1;
         data_out_d = rd_word[DATA_BITS-1:0];
         // With error dropping enabled only error-free frames are stored,
         // so this field is then always zero.
         err_out_d  = rd_word[WORD_W-1:DATA_BITS];
         ovf_d      = 1'b0;
      end
      if (push_drop) begin
         ovf_d = 1'b1;
      end

      if (push_acc && !pop_acc) begin
         count_d = count_q + CNT_ONE;
      end else if (pop_acc && !push_acc) begin
         count_d = count_q - CNT_ONE;
      end

      empty_d = (count_d == CNT_ZERO);
      full_d  = (count_d >= FULL_TH);
   end

   // RTS hysteresis: drop at the Full threshold, reassert at quarter occupancy.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RTS_SEND: if (count_d >= FULL_TH) state_d = RTS_HOLD;
         RTS_HOLD: if (count_d <= LOW_TH)  state_d = RTS_SEND;
         default:  state_d = RTS_SEND;
      endcase
   end

   // Control and output registers with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         data_out_q <= '0;
         err_out_q  <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         ovf_q      <= 1'b0;
         state_q    <= RTS_SEND;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         data_out_q <= data_out_d;
         err_out_q  <= err_out_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         ovf_q      <= ovf_d;
         state_q    <= state_d;
      end
   end

   // Storage array; contents survive reset, only the pointers are cleared.
   always_ff @(posedge Clk) begin
      if (Rst && push_acc) begin
         mem[wr_ptr_q] <= {bus.Err_In, bus.Data_In};
      end
   end

   assign bus.Data_Out      = data_out_q;
   assign bus.Err_Out       = err_out_q;
   assign bus.Count         = count_q;
   assign bus.FIFO_Empty    = empty_q;
   assign bus.FIFO_Full     = full_q;
   assign bus.FIFO_Overflow = ovf_q;
   assign bus.RTS           = (state_q == RTS_SEND);
   assign bus.Rts_Hold_Dbg  = (state_q == RTS_HOLD);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo (FIFO_WIDTH=3, 8 entries): directed test-plan
// sequences with literal checks, then randomized push/pop/reset traffic,
// all compared every cycle against a queue-based model of the FIFO.
module tb_uart_rx_fifo;
   localparam int DW = 8;
   localparam int FW = 3;
   localparam int ENT = 8;

   logic clk;
   logic rst;

   uart_rx_fifo_if #(.DATA_BITS(DW), .FIFO_WIDTH(FW)) bus ();

   uart_rx_fifo #(.DATA_BITS(DW), .FIFO_WIDTH(FW)) dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus.slave)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard / model ----------------
   int vectors = 0;
   int miscompares = 0;

   logic [DW+2:0] exp_q[$];
   logic [DW-1:0] m_dout;
   logic [2:0]    m_eout;
   logic          m_ovf;
   logic          m_rts;
   bit            chk_en = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: spec-level behaviour of one clock edge using a queue.
   always @(posedge clk) begin
      bit pop_ok, push_ok, drop, valid;
      int n;
      if (!rst) begin
         exp_q.delete();
         m_dout = '0;
         m_eout = '0;
         m_ovf  = 1'b0;
         m_rts  = 1'b1;
         chk_en = 1;
      end else begin
`ifdef UART_RX_FIFO_ERR_DROP_EN
         valid = (bus.Err_In == 3'b000);
`else
         valid = 1;
`endif
         pop_ok  = bus.Pop_Data && (exp_q.size() > 0);
         push_ok = bus.Push_Data && valid && (exp_q.size() < ENT || pop_ok);
         drop    = bus.Push_Data && valid && (exp_q.size() == ENT) && !pop_ok;
         if (pop_ok) begin
            {m_eout, m_dout} = exp_q.pop_front();
            m_ovf = 1'b0;
         end
         if (push_ok) exp_q.push_back({bus.Err_In, bus.Data_In});
         if (drop) m_ovf = 1'b1;
         n = exp_q.size();
         if (m_rts && n >= ENT / 2 + 1) m_rts = 1'b0;
         else if (!m_rts && n <= ENT / 4) m_rts = 1'b1;
      end
   end

   // Compare process: every output against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("count",    32'(bus.Count),         32'(exp_q.size()));
         check("empty",    32'(bus.FIFO_Empty),    32'(exp_q.size() == 0));
         check("full",     32'(bus.FIFO_Full),     32'(exp_q.size() >= ENT / 2 + 1));
         check("overflow", 32'(bus.FIFO_Overflow), 32'(m_ovf));
         check("rts",      32'(bus.RTS),           32'(m_rts));
         check("data_out", 32'(bus.Data_Out),      32'(m_dout));
         check("err_out",  32'(bus.Err_Out),       32'(m_eout));
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge: apply inputs for one edge, return at the next negedge.
   task automatic cyc(input bit push, input logic [DW-1:0] d, input logic [2:0] e, input bit pop);
      bus.Push_Data = push;
      bus.Data_In   = d;
      bus.Err_In    = e;
      bus.Pop_Data  = pop;
      @(negedge clk);
      bus.Push_Data = 1'b0;
      bus.Pop_Data  = 1'b0;
   endtask

   task automatic push(input logic [DW-1:0] d);
      cyc(1'b1, d, 3'b000, 1'b0);
   endtask

   task automatic pop();
      cyc(1'b0, '0, 3'b000, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cyc(1'b0, '0, 3'b000, 1'b0);
      cyc(1'b0, '0, 3'b000, 1'b0);
      rst = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b0;
      bus.Push_Data = 1'b0;
      bus.Pop_Data  = 1'b0;
      bus.Data_In   = '0;
      bus.Err_In    = '0;
      @(negedge clk);
      do_reset();
      cyc(1'b0, '0, 3'b000, 1'b0);

      // Reset state
      check("lit_rst_empty", 32'(bus.FIFO_Empty), 32'd1);
      check("lit_rst_full",  32'(bus.FIFO_Full),  32'd0);
      check("lit_rst_rts",   32'(bus.RTS),        32'd1);
      check("lit_rst_count", 32'(bus.Count),      32'd0);
      check("lit_rst_dout",  32'(bus.Data_Out),   32'h00);

      // Ordered push/pop and pop-while-empty
      push(8'h11); push(8'h22); push(8'h33);
      pop(); check("lit_pop1", 32'(bus.Data_Out), 32'h11);
      pop(); check("lit_pop2", 32'(bus.Data_Out), 32'h22);
      pop(); check("lit_pop3", 32'(bus.Data_Out), 32'h33);
      check("lit_empty3", 32'(bus.FIFO_Empty), 32'd1);
      pop(); check("lit_pop4_hold", 32'(bus.Data_Out), 32'h33);

      // Full threshold and RTS hysteresis
      for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
      check("lit_full5",  32'(bus.FIFO_Full), 32'd1);
      check("lit_rts5",   32'(bus.RTS),       32'd0);
      check("lit_cnt5",   32'(bus.Count),     32'd5);
      pop(); pop();
      check("lit_rts3",   32'(bus.RTS),       32'd0);
      check("lit_cnt3",   32'(bus.Count),     32'd3);
      pop();
      check("lit_rts2",   32'(bus.RTS),       32'd1);
      check("lit_cnt2",   32'(bus.Count),     32'd2);
      pop(); pop();

      // Overflow and push+pop while full
      for (int i = 0; i < 9; i++) push(8'(i));
      check("lit_ovf_set", 32'(bus.FIFO_Overflow), 32'd1);
      check("lit_cnt8",    32'(bus.Count),         32'd8);
      pop();
      check("lit_ovf_pop", 32'(bus.Data_Out),      32'h00);
      check("lit_ovf_clr", 32'(bus.FIFO_Overflow), 32'd0);
      push(8'h09);
      cyc(1'b1, 8'h0A, 3'b000, 1'b1);
      check("lit_pp_cnt",  32'(bus.Count),    32'd8);
      check("lit_pp_dout", 32'(bus.Data_Out), 32'h01);
      for (int i = 0; i < 8; i++) pop();
      check("lit_drain_dout", 32'(bus.Data_Out), 32'h0A);

      // Errored frame
      cyc(1'b1, 8'hAA, 3'b010, 1'b0);
`ifdef UART_RX_FIFO_ERR_DROP_EN
      check("lit_err_cnt",   32'(bus.Count),      32'd0);
      check("lit_err_empty", 32'(bus.FIFO_Empty), 32'd1);
`else
      pop();
      check("lit_err_dout", 32'(bus.Data_Out), 32'hAA);
      check("lit_err_eout", 32'(bus.Err_Out),  32'(3'b010));
`endif

      // Reset mid-operation with a push in the reset cycle
      for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
      rst = 1'b0;
      cyc(1'b1, 8'h77, 3'b000, 1'b0);
      rst = 1'b1;
      check("lit_mrst_cnt",   32'(bus.Count),      32'd0);
      check("lit_mrst_empty", 32'(bus.FIFO_Empty), 32'd1);
      check("lit_mrst_rts",   32'(bus.RTS),        32'd1);
      push(8'h5A);
      pop();
      check("lit_mrst_5a", 32'(bus.Data_Out), 32'h5A);

      // Randomized traffic with phases biased toward fill and drain
      for (int i = 0; i < 3000; i++) begin
         int phase;
         bit p, q;
         phase = (i / 300) % 3;
         p = ($urandom_range(0, 99) < (phase == 0 ? 80 : (phase == 1 ? 30 : 50)));
         q = ($urandom_range(0, 99) < (phase == 0 ? 25 : (phase == 1 ? 75 : 50)));
         rst = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
         cyc(p, 8'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000, q);
      end
      rst = 1'b1;
      cyc(1'b0, '0, 3'b000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
